// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;
   localparam int AddrLen    = 32;
   localparam int InstLen    = 32;
   localparam int ICacheIdxW = 7;
   localparam logic [AddrLen-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {IF_IDLE, IF_REQ, IF_RECV, IF_DRAIN} if_state_e;

   function automatic logic [AddrLen-1:0] word_align(input logic [AddrLen-1:0] a);
      return {a[AddrLen-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: async read, sync write.
module inst_fetch_icache
   import inst_fetch_pkg::*;
#(
   parameter int IDX_W = ICacheIdxW
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AddrLen-1:2]   rd_addr_i,
   output logic                 hit_o,
   output logic [InstLen-1:0]   data_o,
   input  logic                 wr_en_i,
   input  logic [AddrLen-1:2]   wr_addr_i,
   input  logic [InstLen-1:0]   wr_data_i
);
   localparam int TAG_W = AddrLen - 2 - IDX_W;
   localparam int LINES = 2 ** IDX_W;

   logic [TAG_W-1:0]   tag_q   [LINES];
   logic [InstLen-1:0] data_q  [LINES];
   logic [LINES-1:0]   valid_q;

   logic [IDX_W-1:0] rd_idx, wr_idx;
   assign rd_idx = rd_addr_i[2 +: IDX_W];
   assign wr_idx = wr_addr_i[2 +: IDX_W];

   assign hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_addr_i[AddrLen-1 -: TAG_W]);
   assign data_o = data_q[rd_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i)        valid_q         <= '0;
      else if (wr_en_i) valid_q[wr_idx] <= 1'b1;
   end

   // Tag/data need no reset: valid bits gate every read.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx]  <= wr_addr_i[AddrLen-1 -: TAG_W];
         data_q[wr_idx] <= wr_data_i;
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: icache lookup, byte-serial miss refill, one-entry PC buffer, flush.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int ICACHE_IDX_W = ICacheIdxW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic [AddrLen-1:0]  pc_i,
   input  logic                pc_valid_i,
   output logic                pc_reg_stall,
   input  logic                jump_or_not,
   output logic                mem_req_o,
   output logic [AddrLen-1:0]  mem_addr_o,
   input  logic                mem_grant_i,
   input  logic [7:0]          mem_byte_i,
   input  logic                mem_byte_valid_i,
   output logic [InstLen-1:0]  inst_o,
   output logic [AddrLen-1:0]  inst_pc_o,
   output logic                inst_valid_o,
   input  logic                id_stall_i
);
   if_state_e          state_q;
   logic [2:0]         cnt_q;        // byte lane in RECV, bytes left in DRAIN
   logic [23:0]        word_q;
   logic               pb_valid_q;
   logic [AddrLen-1:0] pb_pc_q, fetch_pc_q, mem_addr_q, inst_pc_q;
   logic [InstLen-1:0] inst_q, cache_data, fill_word;
   logic               mem_req_q, inst_valid_q, hit, out_blocked, take, fill_en;
   logic [AddrLen-1:0] lk_pc;
   logic [2:0]         flush_rem;

   assign out_blocked = inst_valid_q && id_stall_i;
   assign take        = pb_valid_q || pc_valid_i;
   assign lk_pc       = pb_valid_q ? pb_pc_q : pc_i;
   assign fill_word   = {mem_byte_i, word_q};
   assign fill_en     = rdy && !jump_or_not && (state_q == IF_RECV) && mem_byte_valid_i && (cnt_q == 3'd3);
   assign flush_rem   = (state_q == IF_RECV) ? 3'd4 - cnt_q - {2'b00, mem_byte_valid_i}
                                             : cnt_q - {2'b00, mem_byte_valid_i};

   assign pc_reg_stall = (state_q != IF_IDLE) || pb_valid_q || (pc_valid_i && !hit) || out_blocked;

   inst_fetch_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
      .clk_i     (clk),
      .rst_i     (rst),
      .rd_addr_i (lk_pc[AddrLen-1:2]),
      .hit_o     (hit),
      .data_o    (cache_data),
      .wr_en_i   (fill_en),
      .wr_addr_i (fetch_pc_q[AddrLen-1:2]),
      .wr_data_i (fill_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IF_IDLE;
         cnt_q        <= '0;
         word_q       <= '0;
         pb_valid_q   <= 1'b0;
         pb_pc_q      <= ZERO_WORD;
         fetch_pc_q   <= ZERO_WORD;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= ZERO_WORD;
         inst_q       <= '0;
         inst_pc_q    <= ZERO_WORD;
         inst_valid_q <= 1'b0;
      end else if (rdy) begin
         if (!out_blocked) inst_valid_q <= 1'b0;
         if (jump_or_not) begin
            inst_valid_q <= 1'b0;
            pb_valid_q   <= 1'b0;
            case (state_q)
               IF_REQ: begin
                  mem_req_q <= 1'b0;
                  if (mem_grant_i) begin
                     state_q <= IF_DRAIN;
                     cnt_q   <= 3'd4;
                  end else begin
                     state_q <= IF_IDLE;
                  end
               end
               IF_RECV, IF_DRAIN: begin
                  cnt_q   <= flush_rem;
                  state_q <= (flush_rem == 3'd0) ? IF_IDLE : IF_DRAIN;
               end
               default: ;
            endcase
         end else begin
            case (state_q)
               IF_IDLE: begin
                  if (take && out_blocked) begin
                     pb_valid_q <= 1'b1;
                     pb_pc_q    <= lk_pc;
                  end else if (take) begin
                     pb_valid_q <= 1'b0;
                     if (hit) begin
                        inst_q       <= cache_data;
                        inst_pc_q    <= lk_pc;
                        inst_valid_q <= 1'b1;
                     end else begin
                        fetch_pc_q <= lk_pc;
                        mem_addr_q <= word_align(lk_pc);
                        mem_req_q  <= 1'b1;
                        state_q    <= IF_REQ;
                     end
                  end
               end
               IF_REQ: begin
                  if (mem_grant_i) begin
                     mem_req_q <= 1'b0;
                     cnt_q     <= '0;
                     state_q   <= IF_RECV;
                  end
               end
               IF_RECV: begin
                  if (mem_byte_valid_i) begin
                     if (cnt_q == 3'd3) begin
                        state_q <= IF_IDLE;
                        // Decode still holds an older word: park the PC, it re-hits once filled.
                        if (out_blocked) begin
                           pb_valid_q <= 1'b1;
                           pb_pc_q    <= fetch_pc_q;
                        end else begin
                           inst_q       <= fill_word;
                           inst_pc_q    <= fetch_pc_q;
                           inst_valid_q <= 1'b1;
                        end
                     end else begin
                        word_q[{cnt_q[1:0], 3'b000} +: 8] <= mem_byte_i;
                        cnt_q <= cnt_q + 3'd1;
                     end
                  end
               end
               IF_DRAIN: begin
                  if (mem_byte_valid_i) begin
                     cnt_q <= cnt_q - 3'd1;
                     if (cnt_q == 3'd1) state_q <= IF_IDLE;
                  end
               end
               default: state_q <= IF_IDLE;
            endcase
         end
      end
   end

   assign mem_req_o    = mem_req_q;
   assign mem_addr_o   = mem_addr_q;
   assign inst_o       = inst_q;
   assign inst_pc_o    = inst_pc_q;
   assign inst_valid_o = inst_valid_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order scoreboard of {pc, inst}.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, pc_valid_i, jump_or_not, mem_grant_i, mem_byte_valid_i, id_stall_i;
   logic [31:0] pc_i;
   logic [7:0]  mem_byte_i;
   logic        pc_reg_stall, mem_req_o, inst_valid_o;
   logic [31:0] mem_addr_o, inst_o, inst_pc_o;

   typedef struct packed {logic [31:0] pc; logic [31:0] inst;} exp_t;
   exp_t sb[$];
   int   vecs = 0;
   int   errs = 0;

   inst_fetch #(.ICACHE_IDX_W(7)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
      .pc_reg_stall(pc_reg_stall), .jump_or_not(jump_or_not),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_grant_i(mem_grant_i),
      .mem_byte_i(mem_byte_i), .mem_byte_valid_i(mem_byte_valid_i),
      .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
      .id_stall_i(id_stall_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0) return 32'h00100513;
      return {8'hA5, a[7:0], ~a[7:0], a[7:0] + 8'h3C};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A word counts as delivered on a clock where it is valid, not stalled and not flushed.
   always @(negedge clk) begin
      if (!rst && rdy && !jump_or_not && inst_valid_o && !id_stall_i) begin
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $error("FAIL unexpected_out: observed pc %h expected no output", inst_pc_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_pc", inst_pc_o, e.pc);
            chk("out_inst", inst_o, e.inst);
         end
      end
   end

   task automatic miss_fill(input logic [31:0] pc, input bit rdy_gap);
      logic [31:0] w;
      w = word_at(pc);
      pc_i = pc; pc_valid_i = 1'b1;
      #1 chk("miss_stall", pc_reg_stall, 1);
      sb.push_back('{pc, w});
      tick();
      pc_valid_i = 1'b0;
      chk("req_up", mem_req_o, 1);
      chk("req_addr", mem_addr_o, {pc[31:2], 2'b00});
      if (rdy_gap) begin
         rdy = 1'b0; tick();
         chk("req_hold", mem_req_o, 1);
         rdy = 1'b1;
      end
      mem_grant_i = 1'b1; tick(); mem_grant_i = 1'b0;
      chk("req_drop", mem_req_o, 0);
      for (int i = 0; i < 4; i++) begin
         mem_byte_valid_i = 1'b1; mem_byte_i = w[8*i +: 8];
         tick();
         if (rdy_gap && i == 1) begin
            rdy = 1'b0; mem_byte_i = 8'hEE; tick();
            chk("rdy_frozen", inst_valid_o, 0);
            rdy = 1'b1;
         end
      end
      mem_byte_valid_i = 1'b0;
      chk("fill_valid", inst_valid_o, 1);
      chk("fill_pc", inst_pc_o, pc);
      chk("fill_inst", inst_o, w);
      chk("fill_stall", pc_reg_stall, 0);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; pc_i = '0; pc_valid_i = 1'b0; jump_or_not = 1'b0;
      mem_grant_i = 1'b0; mem_byte_i = '0; mem_byte_valid_i = 1'b0; id_stall_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_valid", inst_valid_o, 0);
      chk("rst_req", mem_req_o, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_inst_pc", inst_pc_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_stall", pc_reg_stall, 0);
      tick();

      // cold misses fill 0x0, 0x4, 0x8
      miss_fill(32'h0, 0); tick();
      miss_fill(32'h4, 0); tick();
      miss_fill(32'h8, 0); tick();

      // hit stream, one PC per cycle
      for (int i = 0; i < 3; i++) begin
         pc_i = 32'(4 * i); pc_valid_i = 1'b1;
         sb.push_back('{32'(4 * i), word_at(32'(4 * i))});
         #1 chk("hit_stall", pc_reg_stall, 0);
         if (i > 0) chk("hit_valid", inst_valid_o, 1);
         tick();
      end
      pc_valid_i = 1'b0;
      chk("hit_valid_last", inst_valid_o, 1);
      tick();
      chk("hit_valid_clr", inst_valid_o, 0);

      // backpressure: word 0 held, PC 4 parked in PB
      pc_i = 32'h0; pc_valid_i = 1'b1; sb.push_back('{32'h0, word_at(32'h0)});
      tick();
      id_stall_i = 1'b1; pc_i = 32'h4; sb.push_back('{32'h4, word_at(32'h4)});
      #1 chk("bp_stall_in", pc_reg_stall, 1);
      tick();
      pc_valid_i = 1'b0;
      chk("bp_hold_valid", inst_valid_o, 1);
      chk("bp_hold_pc", inst_pc_o, 32'h0);
      chk("bp_hold_inst", inst_o, word_at(32'h0));
      chk("bp_pb_stall", pc_reg_stall, 1);
      tick();
      chk("bp_hold_pc2", inst_pc_o, 32'h0);
      id_stall_i = 1'b0;
      #1 chk("bp_pb_stall2", pc_reg_stall, 1);
      tick();
      chk("bp_pb_pc", inst_pc_o, 32'h4);
      chk("bp_pb_inst", inst_o, word_at(32'h4));
      chk("bp_release_stall", pc_reg_stall, 0);
      tick();

      // flush in IDLE discards the PC of that cycle
      jump_or_not = 1'b1; pc_i = 32'h4; pc_valid_i = 1'b1;
      tick();
      jump_or_not = 1'b0; pc_valid_i = 1'b0;
      chk("flush_idle_valid", inst_valid_o, 0);
      tick();

      // flush mid-RECV after 2 bytes
      pc_i = 32'h10; pc_valid_i = 1'b1;
      #1 chk("fr_miss", pc_reg_stall, 1);
      tick(); pc_valid_i = 1'b0;
      chk("fr_req", mem_req_o, 1);
      mem_grant_i = 1'b1; tick(); mem_grant_i = 1'b0;
      mem_byte_valid_i = 1'b1; mem_byte_i = 8'h11; tick();
      mem_byte_i = 8'h22; tick();
      mem_byte_valid_i = 1'b0; jump_or_not = 1'b1; tick(); jump_or_not = 1'b0;
      chk("fr_drain_stall", pc_reg_stall, 1);
      for (int i = 0; i < 2; i++) begin
         mem_byte_valid_i = 1'b1; mem_byte_i = 8'h77; tick();
         chk("fr_no_valid", inst_valid_o, 0);
      end
      mem_byte_valid_i = 1'b0;
      #1 chk("fr_idle_stall", pc_reg_stall, 0);
      tick();
      miss_fill(32'h10, 0); tick();

      // flush with grant in the same cycle
      pc_i = 32'h20; pc_valid_i = 1'b1;
      tick(); pc_valid_i = 1'b0;
      chk("fg_req", mem_req_o, 1);
      mem_grant_i = 1'b1; jump_or_not = 1'b1; tick();
      mem_grant_i = 1'b0; jump_or_not = 1'b0;
      chk("fg_req_drop", mem_req_o, 0);
      chk("fg_drain_stall", pc_reg_stall, 1);
      for (int i = 0; i < 4; i++) begin
         mem_byte_valid_i = 1'b1; mem_byte_i = 8'h99; tick();
         chk("fg_no_valid", inst_valid_o, 0);
      end
      mem_byte_valid_i = 1'b0;
      #1 chk("fg_idle_stall", pc_reg_stall, 0);
      tick();
      miss_fill(32'h20, 0); tick();

      // rdy low in REQ and RECV
      miss_fill(32'h30, 1); tick();

      // same index, different tag evicts line 0
      miss_fill(32'h200, 0); tick();
      miss_fill(32'h0, 0); tick();

      tick(); tick();
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
